addsub_div_ctrl: RTL and testbench



---
 rtl/div_pkg.sv | 12 +
 rtl/addsub_div_ctrl_if.sv | 23 ++
 rtl/addsub_unit.sv | 27 ++
 rtl/addsub_div_ctrl.sv | 109 ++++++++++
 tb/tb_addsub_div_ctrl.sv | 152 +++++++++++++++
 5 files changed

// File: rtl/div_pkg.sv
// Shared encodings and defaults for the add/sub-based restoring divider.
package div_pkg;

  localparam int DEFAULT_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/addsub_div_ctrl_if.sv
// Start/busy/done handshake and operand/result bus of the divide controller.
interface addsub_div_ctrl_if #(
  parameter int WIDTH = 4
);
  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/addsub_unit.sv
// WIDTH-bit ripple adder/subtractor: sub=1 computes a + ~b + 1, cout=1 means a >= b.
module addsub_unit #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  logic [WIDTH-1:0] w_b_x;

  assign w_b_x = b ^ {WIDTH{sub}};

  always_comb begin
    logic w_carry;
    w_carry = sub;
    sum     = '0;
    for (int i = 0; i < WIDTH; i++) begin
      sum[i]  = a[i] ^ w_b_x[i] ^ w_carry;
      w_carry = (a[i] & w_b_x[i]) | (a[i] & w_carry) | (w_b_x[i] & w_carry);
    end
    cout = w_carry;
  end

endmodule

// File: rtl/addsub_div_ctrl.sv
// Restoring divider: one trial subtraction per clock on a shared add/sub unit,
// WIDTH+1 cycles from accept to done; divide-by-zero finishes in one cycle.
module addsub_div_ctrl
  import div_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic            clk,
  input  logic            rst,
  addsub_div_ctrl_if.slave bus
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  state_t           r_state;
  state_t           w_state_nxt;
  // Partial remainder only ever shifts its low WIDTH-1 bits; the full-width
  // final remainder goes straight into r_rem.
  logic [WIDTH-2:0] r_r;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_d;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_quot;
  logic [WIDTH-1:0] r_rem;
  logic             r_dz;

  logic [WIDTH-1:0] w_shift;
  logic [WIDTH-1:0] w_diff;
  logic             w_cout;
  logic [WIDTH-1:0] w_r_nxt;
  logic [WIDTH-1:0] w_q_nxt;
  logic             w_zero;

  assign w_shift = {r_r, r_q[WIDTH-1]};
  assign w_r_nxt = w_cout ? w_diff : w_shift;
  assign w_q_nxt = {r_q[WIDTH-2:0], w_cout};
  assign w_zero  = (bus.divisor == '0);

  addsub_unit #(
    .WIDTH(WIDTH)
  ) u_addsub (
    .a   (w_shift),
    .b   (r_d),
    .sub (1'b1),
    .sum (w_diff),
    .cout(w_cout)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (bus.start) w_state_nxt = w_zero ? DONE : RUN;
      RUN:     if (r_cnt == '0) w_state_nxt = DONE;
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_r    <= '0;
      r_q    <= '0;
      r_d    <= '0;
      r_cnt  <= '0;
      r_quot <= '0;
      r_rem  <= '0;
      r_dz   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_dz <= w_zero;
            if (w_zero) begin
              r_quot <= '1;
              r_rem  <= bus.dividend;
            end else begin
              r_d   <= bus.divisor;
              r_r   <= '0;
              r_q   <= bus.dividend;
              r_cnt <= CW'(WIDTH - 1);
            end
          end
        end
        RUN: begin
          r_r   <= w_r_nxt[WIDTH-2:0];
          r_q   <= w_q_nxt;
          r_cnt <= r_cnt - CW'(1);
          if (r_cnt == '0) begin
            r_quot <= w_q_nxt;
            r_rem  <= w_r_nxt;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy        = (r_state == RUN);
  assign bus.done        = (r_state == DONE);
  assign bus.quotient    = r_quot;
  assign bus.remainder   = r_rem;
  assign bus.div_by_zero = r_dz;

endmodule

// File: tb/tb_addsub_div_ctrl.sv
// Self-checking bench: cycle-level behavioural model of the divider plus directed literal checks.
module tb_addsub_div_ctrl;

  localparam int W = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  addsub_div_ctrl_if #(.WIDTH(W)) bus();

  addsub_div_ctrl #(.WIDTH(W)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Behavioural model: cycles left in the iteration phase, a done flag, and the
  // arithmetic result computed with / and %.
  int               m_left  = 0;
  bit               m_done  = 0;
  bit               m_valid = 0;
  bit               m_dz    = 0;
  logic [W-1:0]     m_q = '0, m_r = '0, p_q = '0, p_r = '0;

  always @(posedge clk) begin
    if (rst) begin
      m_left = 0; m_done = 0; m_dz = 0; m_q = '0; m_r = '0; m_valid = 1;
    end else if (m_done) begin
      m_done = 0;
    end else if (m_left > 0) begin
      m_left--;
      if (m_left == 0) begin
        m_done = 1; m_q = p_q; m_r = p_r;
      end
    end else if (bus.start) begin
      if (bus.divisor == '0) begin
        m_done = 1; m_q = '1; m_r = bus.dividend; m_dz = 1;
      end else begin
        m_left = W;
        p_q = bus.dividend / bus.divisor;
        p_r = bus.dividend % bus.divisor;
        m_dz = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (m_valid)
      chk("cycle{busy,done,dz,q,r}",
          {bus.busy, bus.done, bus.div_by_zero, bus.quotient, bus.remainder},
          {(m_left > 0), m_done, m_dz, m_q, m_r});
  end

  task automatic do_div(input logic [W-1:0] a, input logic [W-1:0] b,
                        input int eq, input int er, input int edz, input int elat);
    int cyc;
    bit got;
    @(negedge clk);
    bus.start = 1'b1; bus.dividend = a; bus.divisor = b;
    @(negedge clk);
    bus.start = 1'b0; bus.dividend = W'($urandom); bus.divisor = W'($urandom);
    cyc = 1;
    got = bus.done;
    while (!got && cyc < 20) begin
      @(negedge clk);
      cyc++;
      got = bus.done;
    end
    chk($sformatf("latency %0d/%0d", a, b), got ? cyc : 99, elat);
    chk($sformatf("quotient %0d/%0d", a, b), bus.quotient, eq);
    chk($sformatf("remainder %0d/%0d", a, b), bus.remainder, er);
    chk($sformatf("div_by_zero %0d/%0d", a, b), bus.div_by_zero, edz);
  endtask

  initial begin
    int ndone;
    bus.start = 1'b0; bus.dividend = '0; bus.divisor = '0;

    // reset then idle
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("reset outputs", {bus.busy, bus.done, bus.div_by_zero, bus.quotient, bus.remainder}, 0);
    ndone = 0;
    repeat (10) begin
      @(negedge clk);
      if (bus.done) ndone++;
    end
    chk("idle no done", ndone, 0);

    do_div(13, 3, 4, 1, 0, W + 1);
    do_div(15, 1, 15, 0, 0, W + 1);
    do_div(7, 9, 0, 7, 0, W + 1);
    do_div(15, 15, 1, 0, 0, W + 1);
    do_div(0, 5, 0, 0, 0, W + 1);
    do_div(9, 0, 15, 9, 1, 1);
    do_div(8, 2, 4, 0, 0, W + 1);

    // start while busy is ignored
    @(negedge clk); bus.start = 1'b1; bus.dividend = 14; bus.divisor = 4;
    @(negedge clk); bus.start = 1'b0;
    @(negedge clk); bus.start = 1'b1; bus.dividend = 6; bus.divisor = 3;
    @(negedge clk); bus.start = 1'b0;
    ndone = 0;
    repeat (12) begin
      @(negedge clk);
      if (bus.done) ndone++;
    end
    chk("busy start single done", ndone, 1);
    chk("busy start quotient", bus.quotient, 3);
    chk("busy start remainder", bus.remainder, 2);

    // reset mid-operation
    @(negedge clk); bus.start = 1'b1; bus.dividend = 11; bus.divisor = 2;
    @(negedge clk); bus.start = 1'b0;
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    chk("mid reset outputs", {bus.busy, bus.done, bus.div_by_zero, bus.quotient, bus.remainder}, 0);
    ndone = 0;
    repeat (8) begin
      @(negedge clk);
      if (bus.done) ndone++;
    end
    chk("mid reset no done", ndone, 0);
    do_div(11, 2, 5, 1, 0, W + 1);

    // random traffic, including zero divisors, ignored starts and resets
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      bus.start    = ($urandom % 4) == 0;
      bus.dividend = W'($urandom);
      bus.divisor  = (($urandom % 8) == 0) ? '0 : W'($urandom);
      rst          = ($urandom % 80) == 0;
    end
    @(negedge clk); rst = 1'b0; bus.start = 1'b0;
    repeat (W + 3) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
